// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param: write/read requests, FWFT data and status.
// master drives wr/w_data/rd (and err_clr with FIFO_ERR_EN); slave is the FIFO.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
`ifdef FIFO_ERR_EN
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output wr, w_data, rd, err_clr,
        input  r_data, full, empty, almost_full, almost_empty, level,
        input  overflow, underflow
    );
    modport slave (
        input  wr, w_data, rd, err_clr,
        output r_data, full, empty, almost_full, almost_empty, level,
        output overflow, underflow
    );
`else
    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, almost_full, almost_empty, level
    );
    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, almost_full, almost_empty, level
    );
`endif
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock first-word-fall-through FIFO with level and thresholds.
// Ports: clk, reset_n (async active-low), bus (fifo_sync_param_if.slave).
// Define FIFO_ERR_EN to add sticky overflow/underflow flags cleared by err_clr.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input logic               clk,
    input logic               reset_n,
    fifo_sync_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LVL_AF   = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LVL_AE   = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags come only from the registered level.
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

    // A write on a full FIFO is still taken when a read frees the head slot.
    // A read on an empty FIFO is never taken, even alongside a write.
    assign w_wr_acc = bus.wr & (~w_full | bus.rd);
    assign w_rd_acc = bus.rd & ~w_empty;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign bus.r_data       = r_mem[r_rd_ptr];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_level >= LVL_AF);
    assign bus.almost_empty = (r_level <= LVL_AE);
    assign bus.level        = r_level;

`ifdef FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Setting takes priority over err_clr in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr & w_full & ~bus.rd) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd & w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: queue reference model drives expectations,
// a negedge monitor checks status every cycle and pops read data on each accepted read.
module tb_fifo_sync_param;
    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk;
    logic reset_n;

    fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_sync_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] ref_q [$];
    logic [DW-1:0] exp_q [$];
    int exp_lvl   = 0;
    bit ovf       = 0;
    bit unf       = 0;
    bit exp_ovf   = 0;
    bit exp_unf   = 0;
    bit mon_en    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from occupancy alone.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                        input bit c = 1'b0);
        int  cur;
        bit  wacc;
        bit  racc;
        @(posedge clk);
        #2;
        cur     = ref_q.size();
        exp_lvl = cur;
        exp_ovf = ovf;
        exp_unf = unf;
        bus.wr     = w;
        bus.rd     = r;
        bus.w_data = d;
`ifdef FIFO_ERR_EN
        bus.err_clr = c;
`endif
        wacc = w && (cur < DEPTH || r);
        racc = r && (cur > 0);
        if (racc) exp_q.push_back(ref_q.pop_front());
        if (wacc) ref_q.push_back(d);
        if (w && cur == DEPTH && !r) ovf = 1;
        else if (c)                  ovf = 0;
        if (r && cur == 0)           unf = 1;
        else if (c)                  unf = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("level", int'(bus.level), exp_lvl);
            chk("full", int'(bus.full), int'(exp_lvl == DEPTH));
            chk("empty", int'(bus.empty), int'(exp_lvl == 0));
            chk("almost_full", int'(bus.almost_full), int'(exp_lvl >= AF));
            chk("almost_empty", int'(bus.almost_empty), int'(exp_lvl <= AE));
`ifdef FIFO_ERR_EN
            chk("overflow", int'(bus.overflow), int'(exp_ovf));
            chk("underflow", int'(bus.underflow), int'(exp_unf));
`endif
            if (bus.rd && !bus.empty) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    chk("r_data", int'(bus.r_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic rand_phase(input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(99) < pw, $urandom_range(99) < pr,
                 DW'($urandom));
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.w_data = '0;
`ifdef FIFO_ERR_EN
        bus.err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", int'(bus.level), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_ae", int'(bus.almost_empty), 1);
        chk("rst_af", int'(bus.almost_full), 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        exp_lvl = 0;
        mon_en  = 1'b1;

        // Three writes then three reads.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, DW'(i));
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
        idle(1);

        // Fill to full, one dropped write, drain.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 4'hA);
        idle(1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
        idle(1);

        // Simultaneous access while full.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b1, 4'h5);
        idle(1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);

        // Simultaneous access while empty.
        step(1'b1, 1'b1, 4'h9);
        idle(1);
        step(1'b0, 1'b1, '0);
        idle(1);

        // Interleaved traffic around level 3 to wrap the pointers.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b0, DW'($urandom));
            else            step(1'b0, 1'b1, '0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);

        // Error flags: underflow, overflow, clear, set-beats-clear.
        step(1'b0, 1'b1, '0);
        idle(1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'($urandom));
        step(1'b1, 1'b0, 4'h3);
        idle(1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 4'h7, 1'b1);
        idle(1);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
        idle(1);

        // Randomised phases: fill-biased, drain-biased, balanced.
        rand_phase(150, 80, 30);
        rand_phase(150, 30, 80);
        rand_phase(200, 60, 60);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom));
        @(posedge clk);
        #2;
        mon_en  = 1'b0;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_level", int'(bus.level), 0);
        chk("async_rst_empty", int'(bus.empty), 1);
        ref_q.delete();
        exp_q.delete();
        ovf = 0;
        unf = 0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        exp_lvl = 0;
        exp_ovf = 0;
        exp_unf = 0;
        mon_en  = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(i + 6));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        idle(2);

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
